// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus bundle.
// Groups the two requester handshakes (ex, ld), the issue-side pending-set
// request, and the register-file write port plus scoreboard outputs.
//   master : requesters / issue logic / register file side
//   slave  : the arbiter itself
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic                    ex_valid;
   logic [0:ADDR_W-1]       ex_addr;
   logic [0:DATA_W-1]       ex_data;
   logic                    ex_ready;
   logic                    ld_valid;
   logic [0:ADDR_W-1]       ld_addr;
   logic [0:DATA_W-1]       ld_data;
   logic                    ld_ready;
   logic                    pend_set;
   logic [0:ADDR_W-1]       pend_addr;
   logic                    wb_en;
   logic [0:ADDR_W-1]       wb_addr;
   logic [0:DATA_W-1]       wb_data;
   logic [0:2**ADDR_W-1]    pending;
   logic                    last_grant;

   modport master (
      output ex_valid, ex_addr, ex_data, ld_valid, ld_addr, ld_data,
             pend_set, pend_addr,
      input  ex_ready, ld_ready, wb_en, wb_addr, wb_data, pending, last_grant
   );

   modport slave (
      input  ex_valid, ex_addr, ex_data, ld_valid, ld_addr, ld_data,
             pend_set, pend_addr,
      output ex_ready, ld_ready, wb_en, wb_addr, wb_data, pending, last_grant
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the execute result
// path (ex) and the load/NIC return path (ld) with round-robin arbitration,
// and keeps a per-register pending scoreboard for RAW hazard stalls.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : regfile_wb_arbiter_if.slave
//            ex_/ld_ valid/addr/data in, ex_/ld_ready out (combinational)
//            pend_set/pend_addr in
//            wb_en/wb_addr/wb_data out (registered write port)
//            pending out (bit i = register i has an outstanding write)
//            last_grant out (0 = ex granted last, 1 = ld granted last)
module regfile_wb_arbiter #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int NREG = 2**ADDR_W;

   logic                gnt_ex, gnt_ld;
   logic [0:ADDR_W-1]   sel_addr;
   logic [0:DATA_W-1]   sel_data;

   logic                wb_en_q, wb_en_d;
   logic [0:ADDR_W-1]   wb_addr_q, wb_addr_d;
   logic [0:DATA_W-1]   wb_data_q, wb_data_d;
   logic                last_grant_q, last_grant_d;
   logic [0:NREG-1]     pending_q, pending_d;

   // Grant: a lone valid wins; on a tie the source not named by last_grant
   // wins. Only valids and last_grant feed this, never addr/data.
   always_comb begin
      gnt_ex = !reset && bus.ex_valid && (!bus.ld_valid ||  last_grant_q);
      gnt_ld = !reset && bus.ld_valid && (!bus.ex_valid || !last_grant_q);
   end

   assign sel_addr = gnt_ld ? bus.ld_addr : bus.ex_addr;
   assign sel_data = gnt_ld ? bus.ld_data : bus.ex_data;

   always_comb begin
      wb_en_d      = 1'b0;
      wb_addr_d    = wb_addr_q;
      wb_data_d    = wb_data_q;
      last_grant_d = last_grant_q;
      if (gnt_ex || gnt_ld) begin
         last_grant_d = gnt_ld;
         // Register 0 is hardwired: accept the request but never write it.
         if (sel_addr != '0) begin
            wb_en_d   = 1'b1;
            wb_addr_d = sel_addr;
            wb_data_d = sel_data;
         end
      end
   end

   // Clear on the edge that commits the write; a set at the same edge wins
   // because it marks a newer producer.
   always_comb begin
      pending_d = pending_q;
      if (wb_en_q)
         pending_d[wb_addr_q] = 1'b0;
      if (bus.pend_set && (bus.pend_addr != '0))
         pending_d[bus.pend_addr] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_en_q      <= 1'b0;
         wb_addr_q    <= '0;
         wb_data_q    <= '0;
         last_grant_q <= 1'b1;
         pending_q    <= '0;
      end else begin
         wb_en_q      <= wb_en_d;
         wb_addr_q    <= wb_addr_d;
         wb_data_q    <= wb_data_d;
         last_grant_q <= last_grant_d;
         pending_q    <= pending_d;
      end
   end

   assign bus.ex_ready   = gnt_ex;
   assign bus.ld_ready   = gnt_ld;
   assign bus.wb_en      = wb_en_q;
   assign bus.wb_addr    = wb_addr_q;
   assign bus.wb_data    = wb_data_q;
   assign bus.pending    = pending_q;
   assign bus.last_grant = last_grant_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: transaction queues per source feed the
// DUT, a reference model predicts grants, writes and the pending set, and a
// monitor pops expected writes from a scoreboard queue.
module tb_regfile_wb_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();
   regfile_wb_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct { int cyc; logic [4:0] a; logic [63:0] d; } wr_t;
   typedef struct { logic [4:0] a; logic [63:0] d; } req_t;

   wr_t  sbq[$];
   req_t exq[$], ldq[$];

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   bit mon_en = 0;

   // reference state
   logic        lg;
   logic [0:31] pend_exp;
   bit          cur_wr_v;
   logic [4:0]  cur_wr_a;
   bit          g_ex, g_ld;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Present the head of each source queue; data stays put until popped.
   task automatic drive();
      bus.ex_valid = (exq.size() > 0);
      if (exq.size() > 0) begin bus.ex_addr = exq[0].a; bus.ex_data = exq[0].d; end
      bus.ld_valid = (ldq.size() > 0);
      if (ldq.size() > 0) begin bus.ld_addr = ldq[0].a; bus.ld_data = ldq[0].d; end
   endtask

   task automatic push_ex(input logic [4:0] a, input logic [63:0] d);
      req_t r; r.a = a; r.d = d; exq.push_back(r); drive();
   endtask
   task automatic push_ld(input logic [4:0] a, input logic [63:0] d);
      req_t r; r.a = a; r.d = d; ldq.push_back(r); drive();
   endtask

   // One clock: check and predict mid-cycle, then retire accepted requests.
   task automatic tick();
      logic [0:31] nxt;
      logic [4:0]  a;
      logic [63:0] d;
      wr_t w;
      @(negedge clk);
      g_ex = !reset && (exq.size() > 0) && ((ldq.size() == 0) || lg);
      g_ld = !reset && (ldq.size() > 0) && ((exq.size() == 0) || !lg);
      chk("ex_ready", 64'(bus.ex_ready), 64'(g_ex));
      chk("ld_ready", 64'(bus.ld_ready), 64'(g_ld));
      chk("pending", 64'(bus.pending), 64'(pend_exp));
      chk("last_grant", 64'(bus.last_grant), 64'(lg));
      if (reset) begin
         pend_exp = '0;
         lg = 1'b1;
         cur_wr_v = 0;
      end else begin
         nxt = pend_exp;
         if (cur_wr_v) nxt[cur_wr_a] = 1'b0;
         if (bus.pend_set && bus.pend_addr != 5'd0) nxt[bus.pend_addr] = 1'b1;
         pend_exp = nxt;
         cur_wr_v = 0;
         if (g_ex || g_ld) begin
            lg = g_ld;
            a = g_ld ? ldq[0].a : exq[0].a;
            d = g_ld ? ldq[0].d : exq[0].d;
            if (a != 5'd0) begin
               w.cyc = cyc + 1; w.a = a; w.d = d;
               sbq.push_back(w);
               cur_wr_v = 1;
               cur_wr_a = a;
            end
         end
      end
      @(posedge clk); #1;
      bus.pend_set = 1'b0;
      if (reset) begin
         exq.delete(); ldq.delete();
      end else begin
         if (g_ex) void'(exq.pop_front());
         if (g_ld) void'(ldq.pop_front());
      end
      drive();
   endtask

   task automatic drain(input string nm);
      int k;
      for (k = 0; k < 40 && (exq.size() > 0 || ldq.size() > 0); k++) tick();
      chk({nm, "_timeout"}, 64'(exq.size() + ldq.size()), 64'd0);
      tick(); tick();
   endtask

   task automatic pend(input logic [4:0] a);
      bus.pend_set = 1'b1; bus.pend_addr = a; tick();
   endtask

   // Monitor: every cycle either the scheduled write is on the port or wb_en is low.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            chk("wb_en", 64'(bus.wb_en), 64'd1);
            chk("wb_addr", 64'(bus.wb_addr), 64'(sbq[0].a));
            chk("wb_data", 64'(bus.wb_data), sbq[0].d);
            void'(sbq.pop_front());
         end else begin
            chk("wb_en_idle", 64'(bus.wb_en), 64'd0);
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
               chk("wb_missed", 64'(sbq[0].cyc), 64'(cyc));
               void'(sbq.pop_front());
            end
         end
      end
   end

   initial begin
      bus.ex_valid = 0; bus.ex_addr = '0; bus.ex_data = '0;
      bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_data = '0;
      bus.pend_set = 0; bus.pend_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      lg = 1'b1; pend_exp = '0; cur_wr_v = 0;
      mon_en = 1;
      tick();                       // reset state
      reset = 1'b0;

      // single ex write
      push_ex(5'd5, 64'hDEAD);
      tick(); tick(); tick();

      // tie sequence after a fresh reset: ex1, ld11, ex2, ld12, ...
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         push_ex(5'(i), 64'h1000 + 64'(i));
         push_ld(5'(10 + i), 64'h2000 + 64'(i));
      end
      drain("tie");

      // pend 7 then a load write three cycles later
      pend(5'd7); tick(); tick();
      push_ld(5'd7, 64'h77);
      drain("pend7");

      // set and clear of register 9 at the same edge
      push_ex(5'd9, 64'h99);
      tick();
      pend(5'd9);
      tick();
      chk("pend9_held", 64'(bus.pending[9]), 64'd1);

      // address 0 and pend_set 0
      push_ex(5'd0, 64'h1234);
      pend(5'd0);
      tick();

      // reset with both valid and pending bits 3, 20 set
      pend(5'd3); pend(5'd20);
      push_ex(5'd1, 64'hA1); push_ld(5'd2, 64'hB2);
      push_ex(5'd3, 64'hA3); push_ld(5'd4, 64'hB4);
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      push_ex(5'd6, 64'hC6); push_ld(5'd8, 64'hD8);
      drain("post_reset");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if (exq.size() < 3 && $urandom_range(0, 1))
            push_ex(5'($urandom_range(0, 31)), {$urandom, $urandom});
         if (ldq.size() < 3 && $urandom_range(0, 1))
            push_ld(5'($urandom_range(0, 31)), {$urandom, $urandom});
         if ($urandom_range(0, 2) == 0) begin
            bus.pend_set = 1'b1; bus.pend_addr = 5'($urandom_range(0, 31));
         end
         reset = ($urandom_range(0, 63) == 0);
         tick();
      end
      reset = 1'b0;
      drain("random");
      chk("sb_empty", 64'(sbq.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-register scoreboard for the CPU's 32 x 64-bit register file. It shares the register file's single write port between the execute-stage result path and the memory/NIC load-return path. Requesters use a valid/ready handshake, and grants alternate round-robin. The block also tracks which destination registers have an outstanding write, so the issue logic can stall on read-after-write hazards.

## Interface
Parameters:
- DATA_W, 64, write data width
- ADDR_W, 5, register address width; the file holds 2**ADDR_W registers

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  execute result valid
- ex_addr  in  [0:ADDR_W-1]  execute destination register
- ex_data  in  [0:DATA_W-1]  execute result
- ex_ready  out  1  execute result accepted this cycle (combinational)
- ld_valid  in  1  load/NIC return valid
- ld_addr  in  [0:ADDR_W-1]  load destination register
- ld_data  in  [0:DATA_W-1]  load data
- ld_ready  out  1  load return accepted this cycle (combinational)
- pend_set  in  1  issue logic marks a destination as pending
- pend_addr  in  [0:ADDR_W-1]  register to mark pending
- wb_en  out  1  drives the register file writeEnable
- wb_addr  out  [0:ADDR_W-1]  drives rD_address
- wb_data  out  [0:DATA_W-1]  drives rD_data
- pending  out  [0:2**ADDR_W-1]  bit i is high while register i has an outstanding write
- last_grant  out  1  0 = ex granted last, 1 = ld granted last

## Operation
- Handshake:
  - A transfer occurs when valid && ready are both high.
  - Once a requester asserts valid, it holds valid, addr and data stable until the transfer.
  - ready depends on valid and the arbiter state only. It never depends on the requester's own addr or data.
- Arbitration, one grant per cycle:
  - Only one valid: that source is granted.
  - Both valid: grant the source not named by last_grant.
  - On every grant, last_grant updates to the granted source.
  - Neither valid: no grant, and last_grant holds.
- Same destination on both paths in one cycle: no special handling. The source that loses arbitration waits and writes one cycle later, so the later write wins in the file.
- Address 0:
  - A request targeting register 0 is accepted (ready high, handshake completes).
  - wb_en stays 0 for it, and last_grant still updates.
- Scoreboard:
  - pend_set sets pending[pend_addr].
  - A wb_en=1 cycle clears pending[wb_addr] at the following clock edge.
  - Set and clear of the same register at the same edge: set wins, because a new producer has issued.
  - pending[0] is held at 0, and pend_set with pend_addr=0 is ignored.
  - A write to a non-pending register is legal and leaves pending unchanged.
- Reset:
  - Outputs: wb_en=0, wb_addr=0, wb_data=0, pending=all zeros, last_grant=1 (so ex wins the first tie).
  - ex_ready and ld_ready are 0 while reset is high.
  - In-flight requests are dropped. Requesters must re-present after reset.
  - A wb_en that was high in the cycle reset is applied does not clear pending, because pending is zeroed anyway.

## Timing
- Write-back latency: a transfer accepted at edge N appears on wb_en/wb_addr/wb_data during cycle N..N+1. The register file commits it at edge N+1.
- wb_en, wb_addr and wb_data are registered, with no combinational path from the request inputs.
- wb_en is high for exactly one cycle per accepted non-zero-address request.
- When no transfer occurs, wb_en=0. wb_addr and wb_data hold their previous values.
- Throughput: one write per cycle sustained. With both sources continuously valid, grants alternate ex, ld, ex, ld, ...
- pending[r] falls at the same edge the register file writes r. A read issued in the cycle after pending falls sees the new data.
- pend_set takes effect at the next edge: pending[r] reads high in the following cycle.

## Test plan
- Reset, then ex_valid with addr 5 and data 0xDEAD: ex_ready=1 same cycle. Next cycle wb_en=1, wb_addr=5, wb_data=0xDEAD. The following cycle wb_en=0.
- Both valid for 4 cycles (ex addrs 1-4, ld addrs 11-14): grant order is ex1, ld11, ex2, ld12. Each source's data is held stable while it waits, and every write appears exactly once.
- pend_set addr 7, then ld writes 7 three cycles later: pending[7] is high from the cycle after set until wb_en=1 with wb_addr=7, and low in the next cycle.
- pend_set addr 9 in the same cycle that wb_en=1, wb_addr=9: pending[9] stays 1 after the edge.
- ex_valid with addr 0: ex_ready=1, wb_en stays 0, last_grant=0. pend_set addr 0 leaves pending=0.
- Assert reset while both sources are valid and pending has bits 3 and 20 set: the next cycle shows pending=0, wb_en=0, ready=0 and last_grant=1. After reset is released, ex wins the first tie.
